wb_commit: RTL and testbench

- Writeback stage; consumes the MEM/WB pipe outputs and commits results to the scalar and vector register files.
- Scalar results: written in one beat.
- Vector results: written over several narrow beats through the vector RF write port, holding off the pipe with a ready handshake.
- Sits between the MEM/WB register and the register files; also drives the writeback-to-decode forwarding bus.

---
 rtl/vp_pkg.sv | 27 ++
 rtl/wb_beat_serializer.sv | 99 +++++++++
 rtl/wb_commit.sv | 118 +++++++++++
 tb/tb_wb_commit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// Shared writeback definitions: write codes, FSM states, default widths and beat-count helpers.
package vp_pkg;

  typedef enum logic [1:0] {
    WB_NONE = 2'b00,
    WB_SCL  = 2'b01,
    WB_VEC  = 2'b10,
    WB_MEM  = 2'b11
  } wb_code_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_VEC  = 1'b1
  } wb_state_e;

  localparam int VP_VEC_W  = 192;
  localparam int VP_SCL_W  = 21;
  localparam int VP_BEAT_W = 48;
  localparam int VP_REG_AW = 3;
  localparam int VP_NBEATS = VP_VEC_W / VP_BEAT_W;

  // Beat index width; a single-beat vector still carries a 1-bit index.
  function automatic int beat_idx_w(input int nbeats);
    return (nbeats > 1) ? $clog2(nbeats) : 1;
  endfunction

endpackage

// File: rtl/wb_beat_serializer.sv
// Captures one vector result and emits it as NBEATS ascending write beats.
// With WB_FWD_EN defined the captured value and destination are exposed for forwarding.
module wb_beat_serializer
  import vp_pkg::*;
#(
  parameter int VEC_W  = VP_VEC_W,
  parameter int BEAT_W = VP_BEAT_W,
  parameter int REG_AW = VP_REG_AW,
  localparam int NBEATS = VEC_W / BEAT_W,
  localparam int BCNT_W = beat_idx_w(NBEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [VEC_W-1:0]  data_i,
  input  logic [REG_AW-1:0] dest_i,
  output logic              we_o,
  output logic [REG_AW-1:0] waddr_o,
  output logic [BCNT_W-1:0] beat_o,
  output logic [BEAT_W-1:0] wdata_o,
  output logic              busy_o,
  output logic              last_o
`ifdef WB_FWD_EN
  ,
  output logic [VEC_W-1:0]  cap_o,
  output logic [REG_AW-1:0] dest_o
`endif
);

  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(NBEATS - 1);

  wb_state_e          state_q, state_d;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [VEC_W-1:0]   cap_q, cap_d;
  logic [REG_AW-1:0]  dest_q, dest_d;
  logic [BEAT_W-1:0]  wdata_q, wdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      cap_q   <= '0;
      dest_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      cap_q   <= cap_d;
      dest_q  <= dest_d;
      wdata_q <= wdata_d;
    end
  end

  // A load on the last beat restarts at beat 0 so back-to-back vectors have no bubble.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    cap_d   = cap_q;
    dest_d  = dest_q;
    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          state_d = ST_VEC;
          bcnt_d  = '0;
          cap_d   = data_i;
          dest_d  = dest_i;
        end
      end
      ST_VEC: begin
        if (bcnt_q == LAST_BEAT) begin
          if (load_i) begin
            bcnt_d = '0;
            cap_d  = data_i;
            dest_d = dest_i;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    wdata_d = (state_d == ST_VEC) ? cap_d[int'(bcnt_d)*BEAT_W +: BEAT_W] : wdata_q;
  end

  assign we_o    = (state_q == ST_VEC);
  assign busy_o  = (state_q == ST_VEC);
  assign last_o  = (state_q == ST_VEC) && (bcnt_q == LAST_BEAT);
  assign waddr_o = dest_q;
  assign beat_o  = bcnt_q;
  assign wdata_o = wdata_q;

`ifdef WB_FWD_EN
  assign cap_o  = cap_q;
  assign dest_o = dest_q;
`endif

endmodule

// File: rtl/wb_commit.sv
// Writeback commit stage: one-beat scalar writes, multi-beat vector writes with a ready handshake.
// Optional WB_FWD_EN adds the writeback-to-decode forwarding bus.
module wb_commit
  import vp_pkg::*;
#(
  parameter int VEC_W  = VP_VEC_W,
  parameter int SCL_W  = VP_SCL_W,
  parameter int BEAT_W = VP_BEAT_W,
  parameter int REG_AW = VP_REG_AW,
  localparam int NBEATS = VEC_W / BEAT_W,
  localparam int BCNT_W = beat_idx_w(NBEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        wb,
  input  logic              add_sel,
  input  logic [VEC_W-1:0]  addervv,
  input  logic [SCL_W-1:0]  resALUe,
  input  logic [VEC_W-1:0]  resALUve,
  input  logic [VEC_W-1:0]  memData,
  input  logic [REG_AW-1:0] dest,
  output logic              srf_we,
  output logic [REG_AW-1:0] srf_waddr,
  output logic [SCL_W-1:0]  srf_wdata,
  output logic              vrf_we,
  output logic [REG_AW-1:0] vrf_waddr,
  output logic [BCNT_W-1:0] vrf_beat,
  output logic [BEAT_W-1:0] vrf_wdata,
  output logic              busy
`ifdef WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic              fwd_vec,
  output logic [REG_AW-1:0] fwd_dest,
  output logic [VEC_W-1:0]  fwd_data
`endif
);

  wb_code_e          wb_code;
  logic              accept;
  logic              vec_load;
  logic              ser_busy, ser_last;
  logic [VEC_W-1:0]  vec_src;
  logic              srf_we_q, srf_we_d;
  logic [REG_AW-1:0] srf_waddr_q, srf_waddr_d;
  logic [SCL_W-1:0]  srf_wdata_q, srf_wdata_d;
`ifdef WB_FWD_EN
  logic [VEC_W-1:0]  ser_cap;
  logic [REG_AW-1:0] ser_dest;
`endif

  assign wb_code  = wb_code_e'(wb);
  assign in_ready = !ser_busy || ser_last;
  assign accept   = in_valid && in_ready;
  assign vec_load = accept && ((wb_code == WB_VEC) || (wb_code == WB_MEM));

  always_comb begin
    vec_src = memData;
    if (wb_code == WB_VEC) vec_src = add_sel ? addervv : resALUve;
  end

  always_comb begin
    srf_we_d    = accept && (wb_code == WB_SCL);
    srf_waddr_d = srf_we_d ? dest : srf_waddr_q;
    srf_wdata_d = srf_we_d ? resALUe : srf_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      srf_we_q    <= 1'b0;
      srf_waddr_q <= '0;
      srf_wdata_q <= '0;
    end else begin
      srf_we_q    <= srf_we_d;
      srf_waddr_q <= srf_waddr_d;
      srf_wdata_q <= srf_wdata_d;
    end
  end

  assign srf_we    = srf_we_q;
  assign srf_waddr = srf_waddr_q;
  assign srf_wdata = srf_wdata_q;
  assign busy      = ser_busy;

  wb_beat_serializer #(
    .VEC_W  (VEC_W),
    .BEAT_W (BEAT_W),
    .REG_AW (REG_AW)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load_i  (vec_load),
    .data_i  (vec_src),
    .dest_i  (dest),
    .we_o    (vrf_we),
    .waddr_o (vrf_waddr),
    .beat_o  (vrf_beat),
    .wdata_o (vrf_wdata),
    .busy_o  (ser_busy),
    .last_o  (ser_last)
`ifdef WB_FWD_EN
    ,
    .cap_o   (ser_cap),
    .dest_o  (ser_dest)
`endif
  );

`ifdef WB_FWD_EN
  // Scalar and vector writes never overlap, so busy alone selects the forwarding source.
  assign fwd_valid = srf_we_q || ser_busy;
  assign fwd_vec   = ser_busy;
  assign fwd_dest  = ser_busy ? ser_dest : srf_waddr_q;
  assign fwd_data  = ser_busy ? ser_cap : VEC_W'(srf_wdata_q);
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Directed plus random bench for wb_commit against a queue-of-pending-writes reference model.
module tb_wb_commit;

  localparam int VW = 192;
  localparam int SW = 21;
  localparam int BW = 48;
  localparam int NB = VW / BW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    wb = 2'b00;
  logic          add_sel = 1'b0;
  logic [VW-1:0] addervv = '0;
  logic [SW-1:0] resALUe = '0;
  logic [VW-1:0] resALUve = '0;
  logic [VW-1:0] memData = '0;
  logic [2:0]    dest = '0;
  logic          srf_we;
  logic [2:0]    srf_waddr;
  logic [SW-1:0] srf_wdata;
  logic          vrf_we;
  logic [2:0]    vrf_waddr;
  logic [1:0]    vrf_beat;
  logic [BW-1:0] vrf_wdata;
  logic          busy;
`ifdef WB_FWD_EN
  logic          fwd_valid;
  logic          fwd_vec;
  logic [2:0]    fwd_dest;
  logic [VW-1:0] fwd_data;
`endif

  wb_commit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .wb(wb), .add_sel(add_sel), .addervv(addervv), .resALUe(resALUe),
    .resALUve(resALUve), .memData(memData), .dest(dest),
    .srf_we(srf_we), .srf_waddr(srf_waddr), .srf_wdata(srf_wdata),
    .vrf_we(vrf_we), .vrf_waddr(vrf_waddr), .vrf_beat(vrf_beat),
    .vrf_wdata(vrf_wdata), .busy(busy)
`ifdef WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_vec(fwd_vec), .fwd_dest(fwd_dest), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            vec;
    logic [2:0]    addr;
    int            beat;
    logic [VW-1:0] full;
  } wr_t;

  wr_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  srf_writes = 0;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive(input logic v, input logic [1:0] code, input logic asel, input logic [2:0] d,
                       input logic [SW-1:0] s, input logic [VW-1:0] alu, input logic [VW-1:0] add,
                       input logic [VW-1:0] mem);
    in_valid = v; wb = code; add_sel = asel; dest = d;
    resALUe = s; resALUve = alu; addervv = add; memData = mem;
  endtask

  // One clock: the model accepts only when no writes remain pending, then the current write is checked.
  task automatic cycle();
    bit  acc;
    bit  was_rst;
    wr_t w;
    bit  have;
    logic [VW-1:0] src;
    acc = in_valid && !rst && (q.size() == 0);
    was_rst = rst;
    @(posedge clk);
    if (was_rst) q.delete();
    else if (acc && wb == 2'b01) q.push_back('{vec: 1'b0, addr: dest, beat: 0, full: VW'(resALUe)});
    else if (acc && wb[1]) begin
      src = (wb == 2'b11) ? memData : (add_sel ? addervv : resALUve);
      for (int k = 0; k < NB; k++) q.push_back('{vec: 1'b1, addr: dest, beat: k, full: src});
    end
    #1;
    have = (q.size() != 0);
    if (have) w = q.pop_front();
    else w = '{vec: 1'b0, addr: 3'd0, beat: 0, full: '0};
    chk("srf_we", VW'(srf_we), VW'(have && !w.vec));
    chk("vrf_we", VW'(vrf_we), VW'(have && w.vec));
    chk("busy", VW'(busy), VW'(have && w.vec));
    chk("in_ready", VW'(in_ready), VW'(q.size() == 0));
    if (have && !w.vec) begin
      srf_writes++;
      chk("srf_waddr", VW'(srf_waddr), VW'(w.addr));
      chk("srf_wdata", VW'(srf_wdata), w.full);
    end
    if (have && w.vec) begin
      chk("vrf_waddr", VW'(vrf_waddr), VW'(w.addr));
      chk("vrf_beat", VW'(vrf_beat), VW'(w.beat));
      chk("vrf_wdata", VW'(vrf_wdata), (w.full >> (w.beat * BW)) & VW'({BW{1'b1}}));
    end
    if (was_rst) begin
      chk("rst_srf_waddr", VW'(srf_waddr), '0);
      chk("rst_srf_wdata", VW'(srf_wdata), '0);
      chk("rst_vrf_waddr", VW'(vrf_waddr), '0);
      chk("rst_vrf_beat", VW'(vrf_beat), '0);
      chk("rst_vrf_wdata", VW'(vrf_wdata), '0);
    end
`ifdef WB_FWD_EN
    chk("fwd_valid", VW'(fwd_valid), VW'(have));
    if (have) begin
      chk("fwd_vec", VW'(fwd_vec), VW'(w.vec));
      chk("fwd_dest", VW'(fwd_dest), VW'(w.addr));
      chk("fwd_data", fwd_data, w.full);
    end
    if (was_rst) begin
      chk("rst_fwd_dest", VW'(fwd_dest), '0);
      chk("rst_fwd_data", fwd_data, '0);
    end
`endif
  endtask

  initial begin
    logic [VW-1:0] mem0;
    logic [VW-1:0] alu0;
    logic [VW-1:0] add0;
    int n;
    mem0 = {48'h0123_4567_89AB, 48'hCDEF_0011_2233, 48'h4455_6677_8899, 48'hAABB_CCDD_EEFF};
    alu0 = {8{24'h5A5A5A}};
    add0 = {8{24'hC3C3C3}};

    // Reset held for two cycles, then idle.
    rst = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 3'd0, '0, '0, '0, '0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Scalar commit, then a no-write instruction.
    drive(1'b1, 2'b01, 1'b0, 3'd5, 21'h1ABCD, '0, '0, '0);
    cycle();
    drive(1'b1, 2'b00, 1'b0, 3'd6, 21'h00777, '0, '0, '0);
    cycle();

    // Vector from load data, four beats in ascending order.
    drive(1'b1, 2'b11, 1'b0, 3'd2, '0, alu0, add0, mem0);
    cycle();
    drive(1'b0, 2'b00, 1'b0, 3'd0, '0, '0, '0, '0);
    for (int i = 0; i < NB; i++) cycle();

    // Adder result selected over the vector ALU result.
    drive(1'b1, 2'b10, 1'b1, 3'd7, '0, alu0, add0, mem0);
    cycle();
    drive(1'b0, 2'b00, 1'b0, 3'd0, '0, '0, '0, '0);
    for (int i = 0; i < NB; i++) cycle();

    // Vector then a scalar held valid through the stall; it must commit exactly once.
    n = srf_writes;
    drive(1'b1, 2'b10, 1'b0, 3'd3, '0, alu0, add0, mem0);
    cycle();
    drive(1'b1, 2'b01, 1'b0, 3'd4, 21'h0F0F0, '0, '0, '0);
    for (int i = 0; i < NB; i++) cycle();
    drive(1'b0, 2'b00, 1'b0, 3'd0, '0, '0, '0, '0);
    cycle();
    cycle();
    chk("scalar_once", VW'(srf_writes - n), VW'(1));

    // Vector accepted on the last beat of another vector.
    drive(1'b1, 2'b11, 1'b0, 3'd1, '0, '0, '0, rnd_vec());
    cycle();
    drive(1'b1, 2'b11, 1'b0, 3'd6, '0, '0, '0, rnd_vec());
    for (int i = 0; i < NB; i++) cycle();
    drive(1'b0, 2'b00, 1'b0, 3'd0, '0, '0, '0, '0);
    for (int i = 0; i < NB + 1; i++) cycle();

    // Reset during beat 1 abandons the vector.
    drive(1'b1, 2'b11, 1'b0, 3'd5, '0, '0, '0, mem0);
    cycle();
    drive(1'b0, 2'b00, 1'b0, 3'd0, '0, '0, '0, '0);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    cycle();

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), SW'($urandom), rnd_vec(), rnd_vec(), rnd_vec());
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 3'd0, '0, '0, '0, '0);
    for (int i = 0; i < NB + 2; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
